apple_1_term_bridge: RTL

- Terminal-side counterpart of the Apple-1 WozMon/PIA keyboard and display handshakes.
- Receives host characters on a UART RX line and presents them to the core on kbd_rdy/kbd_data with a 4-phase handshake.
- Accepts core output on dsp_rdy/dsp_data and serialises it on UART TX.
- Sits between the apple_1_WozMon_PIA core and the board UART pins; all logic in one clock domain.

---
 rtl/apple_1_term_bridge.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/apple_1_term_bridge.sv
// Apple-1 terminal bridge: UART RX -> char FIFO -> kbd 4-phase handshake; dsp 4-phase handshake -> UART TX.
// Latency: kbd_rdy one cycle after FIFO non-empty; TX start bit begins the cycle after the dsp latch.
// Backpressure: dsp_ack withheld while TX busy; RX drops into a full FIFO (rx_ovf). APPLE1_CRLF_EN appends LF after CR.

module apple_1_term_bridge_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign rd_en = pop && !empty;
    // a pop frees the slot in the same cycle, so push-while-full-with-pop is accepted
    assign wr_en = push && (!full || rd_en);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module apple_1_term_bridge #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic       kbd_rdy,
    input  logic       kbd_ack,
    output logic [6:0] kbd_data,
    input  logic       dsp_rdy,
    output logic       dsp_ack,
    input  logic [6:0] dsp_data,
    output logic       rx_ovf,
    output logic       rx_ferr
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
`ifdef APPLE1_CRLF_EN
    localparam logic CRLF_EN = 1'b1;
`else
    localparam logic CRLF_EN = 1'b0;
`endif

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {K_IDLE, K_RDY, K_WAIT} kbd_state_t;
    typedef enum logic {D_IDLE, D_ACK} dsp_state_t;

    rx_state_t  rx_state;
    kbd_state_t kbd_state;
    dsp_state_t dsp_state;

    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [6:0]    rx_sh;
    logic          rx_push;
    logic          fifo_pop, fifo_empty, fifo_full;
    logic [6:0]    fifo_head;
    logic          tx_busy, crlf_pend;
    logic [8:0]    tx_sh;
    logic [3:0]    tx_bit;
    logic [CW-1:0] tx_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_push  <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1   <= uart_rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_push <= 1'b0;
            rx_ferr <= 1'b0;
            case (rx_state)
                R_IDLE: if (rx_prev && !rx_s2) begin
                    rx_state <= R_START;
                    rx_cnt   <= '0;
                end
                R_START: if (rx_cnt == HALF_END) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? R_IDLE : R_DATA;
                end else rx_cnt <= rx_cnt + 1'b1;
                R_DATA: if (rx_cnt == BIT_END) begin
                    rx_cnt <= '0;
                    // bit 7 is sampled for timing only; the core is 7-bit ASCII
                    if (rx_bit != 3'd7) rx_sh <= {rx_s2, rx_sh[6:1]};
                    rx_bit <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state <= R_STOP;
                end else rx_cnt <= rx_cnt + 1'b1;
                R_STOP: if (rx_cnt == BIT_END) begin
                    rx_push  <= rx_s2;
                    rx_ferr  <= !rx_s2;
                    rx_state <= R_IDLE;
                end else rx_cnt <= rx_cnt + 1'b1;
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    apple_1_term_bridge_fifo #(.WIDTH(7), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rx_push),
        .push_dat (rx_sh),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign fifo_pop = (kbd_state == K_IDLE) && !fifo_empty && !kbd_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbd_state <= K_IDLE;
            kbd_rdy   <= 1'b0;
            kbd_data  <= '0;
            rx_ovf    <= 1'b0;
        end else begin
            if (rx_push && fifo_full && !fifo_pop) rx_ovf <= 1'b1;
            case (kbd_state)
                K_IDLE: if (fifo_pop) begin
                    kbd_data  <= fifo_head;
                    kbd_rdy   <= 1'b1;
                    kbd_state <= K_RDY;
                end
                K_RDY: if (kbd_ack) begin
                    kbd_rdy   <= 1'b0;
                    kbd_state <= K_WAIT;
                end
                K_WAIT: if (!kbd_ack) kbd_state <= K_IDLE;
                default: kbd_state <= K_IDLE;
            endcase
        end
    end

    // tx_sh holds the bits still to send after the start bit: data[6:0], bit7=0, stop=1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uart_txd  <= 1'b1;
            tx_busy   <= 1'b0;
            crlf_pend <= 1'b0;
            tx_sh     <= '1;
            tx_bit    <= '0;
            tx_cnt    <= '0;
            dsp_ack   <= 1'b0;
            dsp_state <= D_IDLE;
        end else begin
            if (tx_busy) begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt <= '0;
                    if (tx_bit == 4'd9) begin
                        if (crlf_pend) begin
                            tx_sh     <= {2'b10, 7'h0A};
                            uart_txd  <= 1'b0;
                            tx_bit    <= '0;
                            crlf_pend <= 1'b0;
                        end else tx_busy <= 1'b0;
                    end else begin
                        uart_txd <= tx_sh[0];
                        tx_sh    <= {1'b1, tx_sh[8:1]};
                        tx_bit   <= tx_bit + 4'd1;
                    end
                end else tx_cnt <= tx_cnt + 1'b1;
            end
            if (dsp_state == D_IDLE) begin
                if (dsp_rdy && !tx_busy) begin
                    tx_sh     <= {2'b10, dsp_data};
                    uart_txd  <= 1'b0;
                    tx_busy   <= 1'b1;
                    tx_cnt    <= '0;
                    tx_bit    <= '0;
                    crlf_pend <= CRLF_EN && (dsp_data == 7'h0D);
                    dsp_ack   <= 1'b1;
                    dsp_state <= D_ACK;
                end
            end else if (!dsp_rdy) begin
                dsp_ack   <= 1'b0;
                dsp_state <= D_IDLE;
            end
        end
    end
endmodule
